// File: rtl/tmdsencode.sv
// tmdsencode: one TMDS lane encoder. It turns control, video, TERC4 and guard
// symbols into 10-bit words and tracks the DC running disparity of the video
// stream. The pipeline is two stages deep: S1 does the transition-minimising
// step and S2 does DC balancing and the output word.
// o_word is bit-reversed relative to the DVI q_out numbering, so o_word[9]
// carries q_out[0] and is the first bit sent by the serializer.
module tmdsencode #(
  parameter int CHANNEL = 0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [1:0] i_mode,
  input  logic [1:0] i_ctl,
  input  logic [3:0] i_aux,
  input  logic [7:0] i_pix,
  output logic [9:0] o_word
);

  localparam logic [1:0] MODE_CTL   = 2'b00;
  localparam logic [1:0] MODE_VID   = 2'b01;
  localparam logic [1:0] MODE_TERC  = 2'b10;
  localparam logic [1:0] MODE_GUARD = 2'b11;

  // Symbol tables, expressed in DVI q_out bit order.
  localparam logic [9:0] CTL_Q [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  localparam logic [9:0] TERC4_Q [16] = '{
    10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
    10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3};
  localparam logic [9:0] GUARD_Q = (CHANNEL == 1) ? 10'h133 : 10'h2CC;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  logic [3:0] pix_n1;
  logic       use_xnor;
  logic [8:0] qm_d;
  logic [3:0] qm_n1_d;

  // S1 combinational: choose XOR/XNOR chain to minimise transitions.
  always_comb begin
    pix_n1   = ones8(i_pix);
    use_xnor = (pix_n1 > 4'd4) || ((pix_n1 == 4'd4) && !i_pix[0]);
    qm_d     = '0;
    qm_d[0]  = i_pix[0];
    for (int i = 1; i < 8; i++) qm_d[i] = qm_d[i-1] ^ i_pix[i] ^ use_xnor;
    qm_d[8]  = ~use_xnor;
    qm_n1_d  = ones8(qm_d[7:0]);
  end

  logic [1:0] s1_mode;
  logic [1:0] s1_ctl;
  logic [3:0] s1_aux;
  logic [8:0] s1_qm;
  logic [3:0] s1_n1;

  // S1 registers; reset leaves a control/00 symbol in flight.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_mode <= MODE_CTL;
      s1_ctl  <= 2'b00;
      s1_aux  <= '0;
      s1_qm   <= '0;
      s1_n1   <= '0;
    end else begin
      s1_mode <= i_mode;
      s1_ctl  <= i_ctl;
      s1_aux  <= i_aux;
      s1_qm   <= qm_d;
      s1_n1   <= qm_n1_d;
    end
  end

  logic signed [4:0] cnt;
  logic signed [4:0] cnt_nxt;
  logic signed [4:0] bal;
  logic        [4:0] n1x2;
  logic        [9:0] q_nxt;
  logic        [9:0] word_nxt;
  logic        [7:0] qm;
  logic              qm8;

  // S2 combinational: DC balancing for video, table lookup otherwise.
  // bal is n1-n0 of q_m[7:0]; any non-video symbol restarts disparity at 0.
  always_comb begin
    qm      = s1_qm[7:0];
    qm8     = s1_qm[8];
    n1x2    = {s1_n1, 1'b0};
    bal     = $signed(n1x2 - 5'd8);
    q_nxt   = CTL_Q[0];
    cnt_nxt = '0;
    case (s1_mode)
      MODE_CTL:   q_nxt = CTL_Q[s1_ctl];
      MODE_TERC:  q_nxt = TERC4_Q[s1_aux];
      MODE_GUARD: q_nxt = GUARD_Q;
      MODE_VID: begin
        if ((cnt == 5'sd0) || (bal == 5'sd0)) begin
          q_nxt   = {~qm8, qm8, (qm8 ? qm : ~qm)};
          cnt_nxt = qm8 ? (cnt + bal) : (cnt - bal);
        end else if (((cnt > 5'sd0) && (bal > 5'sd0)) ||
                     ((cnt < 5'sd0) && (bal < 5'sd0))) begin
          q_nxt   = {1'b1, qm8, ~qm};
          cnt_nxt = cnt - bal + (qm8 ? 5'sd2 : 5'sd0);
        end else begin
          q_nxt   = {1'b0, qm8, qm};
          cnt_nxt = cnt + bal - (qm8 ? 5'sd0 : 5'sd2);
        end
      end
    endcase
    word_nxt = '0;
    for (int k = 0; k < 10; k++) word_nxt[k] = q_nxt[9-k];
  end

  // S2 registers: output word and running disparity.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_word <= 10'h0AB;
      cnt    <= '0;
    end else begin
      o_word <= word_nxt;
      cnt    <= cnt_nxt;
    end
  end

endmodule
